// File: rtl/blink_pkg.sv
// Shared definitions for the blinker front end: widths and FSM state names.
package blink_pkg;

  localparam int BLINK_WIDTH = 16;
  localparam int BLINK_PRE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    STEP  = 2'd3
  } blink_state_t;

endpackage

// File: rtl/blink_prescaler.sv
// Programmable prescaler: raises fire once every prescale+1 running cycles.
// The compare is done against the live prescale value so that lowering it
// mid-run fires immediately instead of waiting for a wrap of pre_cnt.
module blink_prescaler
  import blink_pkg::*;
#(
  parameter int PRE_W = BLINK_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [PRE_W-1:0] prescale,
  output logic             fire
);

  logic [PRE_W-1:0] pre_cnt;

  assign fire = run && (pre_cnt >= prescale);

  // Phase counter: cleared by loads, advances only while running, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (run) begin
      if (fire) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/blink_counter.sv
// Running count and phase offset source for the blinker, with run/pause/step
// control, a host load port and per-increment tick/wrap pulses.
module blink_counter
  import blink_pkg::*;
#(
  parameter int WIDTH = BLINK_WIDTH,
  parameter int PRE_W = BLINK_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [PRE_W-1:0] prescale,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_count,
  input  logic [WIDTH-1:0] load_offset,
  output logic [WIDTH-1:0] current_count,
  output logic [WIDTH-1:0] offset,
  output logic             tick,
  output logic             wrap,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_PAUSE = PAUSE;
  localparam logic [1:0] ST_STEP  = STEP;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] offset_q;
  logic [WIDTH-1:0] count_inc;
  logic             tick_q;
  logic             wrap_q;
  logic             idle_or_pause;
  logic             handshake;
  logic             pre_run;
  logic             fire;
  logic             incr;

  // Loads are only accepted while the count is parked, so they never race an increment.
  assign idle_or_pause = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
  assign load_ready    = ena && idle_or_pause;
  assign handshake     = load_valid && load_ready;

  // A stop in RUN takes effect at the same edge, so the prescaler must not advance then.
  assign pre_run   = ena && (state_q == ST_RUN) && !stop;
  assign incr      = (pre_run && fire) || (ena && (state_q == ST_STEP));
  assign count_inc = count_q + WIDTH'(1);

  blink_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (pre_run),
    .clear    (handshake),
    .prescale (prescale),
    .fire     (fire)
  );

  // Next-state logic: stop beats step beats start; a same-cycle load cancels a step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (!stop) begin
          if (step) begin
            if (!handshake) begin
              state_d = ST_STEP;
            end
          end else if (start) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_STEP: begin
        state_d = ST_PAUSE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, count, offset and pulse registers; everything freezes while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      offset_q <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      if (handshake) begin
        count_q  <= load_count;
        offset_q <= load_offset;
      end else if (incr) begin
        count_q <= count_inc;
      end
      tick_q <= incr;
      wrap_q <= incr && (count_inc == '0);
    end
  end

  assign current_count = count_q;
  assign offset        = offset_q;
  assign tick          = tick_q && ena;
  assign wrap          = wrap_q && ena;
  assign state         = state_q;

endmodule

// File: tb/tb_blink_counter.sv
// Scoreboard bench for blink_counter: the driver predicts each post-edge
// output set with a behavioural model and queues it; the monitor pops and
// compares one entry after every rising edge.
module tb_blink_counter;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_STEP  = 3;

  typedef struct {
    int count;
    int offset;
    int mode;
    bit tick;
    bit wrap;
    bit ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  prescale = 8'd0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_count = 16'd0;
  logic [15:0] load_offset = 16'd0;
  logic [15:0] current_count;
  logic [15:0] offset;
  logic        tick;
  logic        wrap;
  logic [1:0]  state;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   fail_count = 0;

  int   m_count = 0;
  int   m_offset = 0;
  int   m_pre = 0;
  int   m_mode = M_IDLE;
  bit   m_tick = 1'b0;
  bit   m_wrap = 1'b0;

  blink_counter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .start         (start),
    .stop          (stop),
    .step          (step),
    .prescale      (prescale),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_count    (load_count),
    .load_offset   (load_offset),
    .current_count (current_count),
    .offset        (offset),
    .tick          (tick),
    .wrap          (wrap),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outcome of the next rising edge.
  task automatic applyStimulus(input bit r, input bit e, input bit sa, input bit so,
                               input bit st, input int ps, input bit lv,
                               input int lc, input int lo);
    exp_t ex;
    bit   parked;
    bit   hs;
    bit   inc;
    @(negedge clk);
    rst_n       = r;
    ena         = e;
    start       = sa;
    stop        = so;
    step        = st;
    prescale    = 8'(ps);
    load_valid  = lv;
    load_count  = 16'(lc);
    load_offset = 16'(lo);
    if (!r) begin
      m_count  = 0;
      m_offset = 0;
      m_pre    = 0;
      m_mode   = M_IDLE;
      m_tick   = 1'b0;
      m_wrap   = 1'b0;
    end else if (e) begin
      parked = (m_mode == M_IDLE) || (m_mode == M_PAUSE);
      hs     = lv && parked;
      inc    = 1'b0;
      if (parked) begin
        if (hs) begin
          m_count  = lc % 65536;
          m_offset = lo % 65536;
          m_pre    = 0;
        end
        if (!so) begin
          if (st) begin
            if (!hs) m_mode = M_STEP;
          end else if (sa) begin
            m_mode = M_RUN;
          end
        end
      end else if (m_mode == M_RUN) begin
        if (so) begin
          m_mode = M_PAUSE;
        end else if (m_pre >= (ps % 256)) begin
          m_pre = 0;
          inc   = 1'b1;
        end else begin
          m_pre = m_pre + 1;
        end
      end else begin
        inc    = 1'b1;
        m_mode = M_PAUSE;
      end
      if (inc) m_count = (m_count + 1) % 65536;
      m_tick = inc;
      m_wrap = inc && (m_count == 0);
    end
    ex.count  = m_count;
    ex.offset = m_offset;
    ex.mode   = m_mode;
    ex.tick   = m_tick && e;
    ex.wrap   = m_wrap && e;
    ex.ready  = e && ((m_mode == M_IDLE) || (m_mode == M_PAUSE));
    exp_q.push_back(ex);
  endtask

  // Compare the DUT outputs against one queued expectation.
  task automatic checkOutput(input exp_t ex);
    tests_run++;
    if (current_count !== 16'(ex.count) || offset !== 16'(ex.offset) ||
        state !== 2'(ex.mode) || tick !== ex.tick || wrap !== ex.wrap ||
        load_ready !== ex.ready) begin
      fail_count++;
      $display("[TB] FAIL outputs #%0d: got count=%h offset=%h state=%0d tick=%b wrap=%b ready=%b, expected count=%h offset=%h state=%0d tick=%b wrap=%b ready=%b",
               tests_run, current_count, offset, state, tick, wrap, load_ready,
               16'(ex.count), 16'(ex.offset), ex.mode, ex.tick, ex.wrap, ex.ready);
    end
  endtask

  task automatic idleCycles(input int n, input int ps);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0, 0, ps, 0, 0, 0);
  endtask

  task automatic resetCycle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expectation is consumed shortly after every rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Watchdog so a stuck run still reports and terminates.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Driver: directed scenarios followed by a randomized soak.
  initial begin : driver
    int ps;
    resetCycle();
    resetCycle();

    // Steady counting with prescale 3.
    applyStimulus(1, 1, 1, 0, 0, 3, 0, 0, 0);
    idleCycles(20, 3);

    // Load near the top and roll over at full speed.
    resetCycle();
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 16'hFFFE, 16'h0123);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
    idleCycles(5, 0);

    // Pause, two single steps, resume.
    resetCycle();
    applyStimulus(1, 1, 1, 0, 0, 5, 0, 0, 0);
    idleCycles(15, 5);
    applyStimulus(1, 1, 0, 1, 0, 5, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 5, 0, 0, 0);
    idleCycles(1, 5);
    applyStimulus(1, 1, 0, 0, 1, 5, 0, 0, 0);
    idleCycles(1, 5);
    applyStimulus(1, 1, 1, 0, 0, 5, 0, 0, 0);
    idleCycles(12, 5);

    // All requests together in RUN, then a load attempt while running.
    applyStimulus(1, 1, 1, 1, 1, 5, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0, 1, 1, 16'h1234, 16'h5678);
    // Load racing a step in PAUSE, then a load with a start.
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 1, 1, 16'h00AA, 16'h0055);
    applyStimulus(1, 1, 1, 0, 0, 1, 1, 16'h0100, 16'h0200);
    idleCycles(4, 1);

    // Lowering prescale mid-run with pre_cnt at 50.
    resetCycle();
    applyStimulus(1, 1, 1, 0, 0, 200, 0, 0, 0);
    idleCycles(50, 200);
    idleCycles(10, 2);

    // Enable dropped mid-run, then a reset mid-run near 0x0040.
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 2, 0, 0, 0);
    idleCycles(8, 2);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 16'h003E, 16'h0007);
    idleCycles(2, 0);
    resetCycle();
    idleCycles(3, 0);

    // Randomized soak.
    ps = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) begin
        ps = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4));
      end
      applyStimulus($urandom_range(0, 99) > 1, $urandom_range(0, 99) < 90,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
                    $urandom_range(0, 99) < 10, ps, $urandom_range(0, 99) < 20,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(16'hFFF0, 16'hFFFF))
                                                : int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)));
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests_run++;
      fail_count++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
